// File: rtl/bsg_subtractor_one_hot_pipe.sv
// rtl/bsg_subtractor_one_hot_pipe.sv - pipelined one-hot subtractor with a 2-entry result buffer
//
// Recovers one one-hot addend from a one-hot sum (a_i, index i) and the other
// one-hot addend (b_i, index j): diff_o = one-hot(i - j). With modulo_p=1
// the index wraps mod width_p; with modulo_p=0 a negative index is flagged
// via underflow_o instead.
//
// Ports:
//   clk_lo       clock, posedge
//   reset        synchronous, active-high
//   v_i/ready_o  input handshake; ready_o is registered (buffer not full)
//   a_i          one-hot minuend, output_width_p bits
//   b_i          one-hot subtrahend, width_p bits
//   v_o/yumi_i   output handshake; yumi_i pops the buffer head
//   diff_o       one-hot difference at the head (zero on underflow/error)
//   underflow_o  head result had i < j (modulo_p=0 only)
//   err_o        head operands were not exactly one-hot
module bsg_subtractor_one_hot_pipe #(
    parameter int width_p        = 4,
    parameter int output_width_p = 2 * width_p - 1,
    parameter bit modulo_p       = 1'b0
) (
    input  logic                      clk_lo,
    input  logic                      reset,
    input  logic                      v_i,
    output logic                      ready_o,
    input  logic [output_width_p-1:0] a_i,
    input  logic [width_p-1:0]        b_i,
    output logic                      v_o,
    input  logic                      yumi_i,
    output logic [output_width_p-1:0] diff_o,
    output logic                      underflow_o,
    output logic                      err_o
);

    localparam int ia_w   = (output_width_p > 1) ? $clog2(output_width_p) : 1;
    localparam int ib_w   = (width_p > 1) ? $clog2(width_p) : 1;
    // Two spare bits so i + width_p never overflows before the subtraction.
    localparam int calc_w = ((ia_w > ib_w) ? ia_w : ib_w) + 2;

    typedef struct packed {
        logic [output_width_p-1:0] diff;
        logic                      underflow;
        logic                      err;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_e;

    // ------------------------------------------------------------------
    // Arithmetic on the incoming operands
    // ------------------------------------------------------------------
    logic [ia_w-1:0]   a_idx;
    logic [ib_w-1:0]   b_idx;
    logic [calc_w-1:0] i_ext;
    logic [calc_w-1:0] j_ext;
    logic [calc_w-1:0] k_ext;
    logic              a_ok;
    logic              b_ok;
    entry_t            result;

    always_comb begin
        a_idx = '0;
        b_idx = '0;
        // OR of the set-bit positions: exact index when the input is one-hot;
        // the value is discarded via err when it is not.
        for (int n = 0; n < output_width_p; n++) begin
            if (a_i[n]) a_idx = a_idx | ia_w'(n);
        end
        for (int n = 0; n < width_p; n++) begin
            if (b_i[n]) b_idx = b_idx | ib_w'(n);
        end
        a_ok  = $onehot(a_i);
        b_ok  = $onehot(b_i);
        i_ext = calc_w'(a_idx);
        j_ext = calc_w'(b_idx);

        k_ext  = '0;
        result = '0;
        if (!a_ok || !b_ok) begin
            result.err = 1'b1;
        end else if (i_ext >= j_ext) begin
            k_ext = i_ext - j_ext;
        end else if (modulo_p) begin
            k_ext = i_ext + calc_w'(width_p) - j_ext;
        end else begin
            result.underflow = 1'b1;
        end

        // Re-expand to one-hot only for a valid, non-underflowing result so
        // diff is never multi-hot.
        if (!result.err && !result.underflow) begin
            for (int n = 0; n < output_width_p; n++) begin
                result.diff[n] = (k_ext == calc_w'(n));
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry result buffer
    // ------------------------------------------------------------------
    count_e count_q, count_d;
    logic   ready_q, ready_d;
    logic   wr_ptr_q, wr_ptr_d;
    logic   rd_ptr_q, rd_ptr_d;
    entry_t mem_q [2];
    entry_t mem_d [2];
    logic   accept;
    logic   pop;

    assign accept = v_i & ready_q;
    // An illegal yumi on an empty buffer is ignored so state stays intact.
    assign pop    = yumi_i & (count_q != EMPTY);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q ^ accept;
        rd_ptr_d = rd_ptr_q ^ pop;
        mem_d    = mem_q;
        if (accept) mem_d[wr_ptr_q] = result;
        case ({accept, pop})
            2'b10:   count_d = (count_q == EMPTY) ? ONE : FULL;
            2'b01:   count_d = (count_q == FULL) ? ONE : EMPTY;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL);
    end

    always_ff @(posedge clk_lo) begin
        if (reset) begin
            count_q  <= EMPTY;
            ready_q  <= 1'b1;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            ready_q  <= ready_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    entry_t head;
    assign head        = mem_q[rd_ptr_q];
    assign ready_o     = ready_q;
    assign v_o         = (count_q != EMPTY);
    assign diff_o      = v_o ? head.diff : '0;
    assign underflow_o = v_o & head.underflow;
    assign err_o       = v_o & head.err;

`ifndef SYNTHESIS
    yumi_only_when_valid: assert property (@(posedge clk_lo) disable iff (reset) yumi_i |-> v_o);
`endif

endmodule

// File: tb/tb_bsg_subtractor_one_hot_pipe.sv
// tb/tb_bsg_subtractor_one_hot_pipe.sv - scoreboard bench for bsg_subtractor_one_hot_pipe
module tb_bsg_subtractor_one_hot_pipe;

    localparam int W  = 4;
    localparam int OW = 7;

    logic clk_lo = 1'b0;
    always #5 clk_lo = ~clk_lo;

    logic          reset;
    logic          v_i, yumi_i;
    logic [OW-1:0] a_i;
    logic [W-1:0]  b_i;
    logic          ready_o, v_o, underflow_o, err_o;
    logic [OW-1:0] diff_o;

    logic          m_v_i, m_yumi_i;
    logic [W-1:0]  m_a_i, m_b_i;
    logic          m_ready_o, m_v_o, m_underflow_o, m_err_o;
    logic [W-1:0]  m_diff_o;

    bsg_subtractor_one_hot_pipe #(.width_p(W), .output_width_p(OW), .modulo_p(1'b0)) dut (
        .clk_lo(clk_lo), .reset(reset), .v_i(v_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .v_o(v_o), .yumi_i(yumi_i),
        .diff_o(diff_o), .underflow_o(underflow_o), .err_o(err_o)
    );

    bsg_subtractor_one_hot_pipe #(.width_p(W), .output_width_p(W), .modulo_p(1'b1)) dut_mod (
        .clk_lo(clk_lo), .reset(reset), .v_i(m_v_i), .ready_o(m_ready_o),
        .a_i(m_a_i), .b_i(m_b_i), .v_o(m_v_o), .yumi_i(m_yumi_i),
        .diff_o(m_diff_o), .underflow_o(m_underflow_o), .err_o(m_err_o)
    );

    typedef struct packed {
        logic [OW-1:0] diff;
        logic          uf;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t model(input logic [OW-1:0] a, input logic [W-1:0] b);
        int   na, nb, i, j;
        exp_t e;
        na = 0; nb = 0; i = 0; j = 0;
        for (int n = 0; n < OW; n++) if (a[n]) begin na++; i = n; end
        for (int n = 0; n < W; n++)  if (b[n]) begin nb++; j = n; end
        e = '0;
        if (na != 1 || nb != 1) e.err = 1'b1;
        else if (i < j)         e.uf  = 1'b1;
        else                    e.diff = OW'(1) << (i - j);
        return e;
    endfunction

    // Scoreboard: push on accept, pop/compare on yumi, both judged just
    // before the posedge at which they take effect.
    always @(negedge clk_lo) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (v_o && yumi_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_output diff=%b uf=%b err=%b", diff_o, underflow_o, err_o);
                end else begin
                    mon_e = sb.pop_front();
                    if ({diff_o, underflow_o, err_o} !== mon_e) begin
                        errors++;
                        $display("FAIL sb_result got diff=%b uf=%b err=%b want diff=%b uf=%b err=%b",
                                 diff_o, underflow_o, err_o, mon_e.diff, mon_e.uf, mon_e.err);
                    end
                end
            end
            if (v_i && ready_o) sb.push_back(model(a_i, b_i));
        end
    end

    task automatic step();
        @(posedge clk_lo);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; v_i = 0; yumi_i = 0; a_i = '0; b_i = '0;
        m_v_i = 0; m_yumi_i = 0; m_a_i = '0; m_b_i = '0;
        step(); step();
        reset = 1'b0;
        step();
        checks++;
        if ({ready_o, v_o, diff_o, underflow_o, err_o} !== {1'b1, 1'b0, {OW{1'b0}}, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b diff=%b uf=%b err=%b want rdy=1 v=0 diff=0 uf=0 err=0",
                     ready_o, v_o, diff_o, underflow_o, err_o);
        end
        checks++;
        if ({m_ready_o, m_v_o, m_diff_o} !== {1'b1, 1'b0, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state_mod got rdy=%b v=%b diff=%b want rdy=1 v=0 diff=0", m_ready_o, m_v_o, m_diff_o);
        end
    endtask

    task automatic test_basic();
        v_i = 1; a_i = 7'b0000100; b_i = 4'b0001; yumi_i = 0;
        step();
        v_i = 0;
        checks++;
        if (v_o !== 1'b1 || diff_o !== 7'b0000100) begin
            errors++;
            $display("FAIL basic_latency got v=%b diff=%b want v=1 diff=0000100", v_o, diff_o);
        end
        yumi_i = 1;
        step();
        yumi_i = 0;
    endtask

    task automatic test_sweep();
        bit first;
        first = 1;
        for (int i = 0; i < OW; i++) begin
            for (int j = 0; j < W; j++) begin
                v_i = 1; a_i = OW'(1) << i; b_i = W'(1) << j;
                yumi_i = first ? 1'b0 : 1'b1;
                first = 0;
                step();
                checks++;
                if (v_o !== 1'b1 || ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep_throughput i=%0d j=%0d got v=%b rdy=%b want v=1 rdy=1", i, j, v_o, ready_o);
                end
            end
        end
        v_i = 0;
        step();
        yumi_i = 0;
        checks++;
        if (v_o !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL sweep_drain got v=%b pending=%0d want v=0 pending=0", v_o, sb.size());
        end
    endtask

    task automatic test_underflow_modulo();
        bit first;
        v_i = 1; a_i = 7'b0000010; b_i = 4'b1000; yumi_i = 0;
        step();
        v_i = 0;
        checks++;
        if (diff_o !== '0 || underflow_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL underflow got diff=%b uf=%b err=%b want diff=0 uf=1 err=0", diff_o, underflow_o, err_o);
        end
        yumi_i = 1;
        step();
        yumi_i = 0;

        first = 1;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                int k;
                k = (i - j + W) % W;
                m_v_i = 1; m_a_i = W'(1) << i; m_b_i = W'(1) << j;
                m_yumi_i = first ? 1'b0 : 1'b1;
                first = 0;
                step();
                checks++;
                if (m_v_o !== 1'b1 || m_diff_o !== (W'(1) << k) || m_underflow_o !== 1'b0 || m_err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL modulo i=%0d j=%0d got v=%b diff=%b uf=%b err=%b want v=1 diff=%b uf=0 err=0",
                             i, j, m_v_o, m_diff_o, m_underflow_o, m_err_o, W'(1) << k);
                end
            end
        end
        m_v_i = 0;
        step();
        m_yumi_i = 0;
    endtask

    task automatic test_backpressure();
        exp_t e0;
        e0 = model(7'b0000010, 4'b0001);
        yumi_i = 0;
        v_i = 1; a_i = 7'b0000010; b_i = 4'b0001;
        step();
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_cycle1 got rdy=%b v=%b want rdy=1 v=1", ready_o, v_o);
        end
        a_i = 7'b0001000;
        step();
        checks++;
        if (ready_o !== 1'b0 || diff_o !== e0.diff) begin
            errors++;
            $display("FAIL bp_cycle2 got rdy=%b diff=%b want rdy=0 diff=%b", ready_o, diff_o, e0.diff);
        end
        a_i = 7'b1000000;
        step();
        checks++;
        if (ready_o !== 1'b0 || v_o !== 1'b1 || diff_o !== e0.diff) begin
            errors++;
            $display("FAIL bp_hold got rdy=%b v=%b diff=%b want rdy=0 v=1 diff=%b", ready_o, v_o, diff_o, e0.diff);
        end
        v_i = 0; yumi_i = 1;
        step();
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=1", ready_o, v_o);
        end
        step();
        yumi_i = 0;
        checks++;
        if (v_o !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain got v=%b pending=%0d want v=0 pending=0", v_o, sb.size());
        end
    endtask

    task automatic test_error();
        logic [OW-1:0] at [4];
        logic [W-1:0]  bt [4];
        at[0] = 7'b0000000; bt[0] = 4'b0010;
        at[1] = 7'b0000110; bt[1] = 4'b0010;
        at[2] = 7'b0000100; bt[2] = 4'b0000;
        at[3] = 7'b0000001; bt[3] = 4'b0011;
        for (int n = 0; n < 4; n++) begin
            v_i = 1; a_i = at[n]; b_i = bt[n];
            yumi_i = (n == 0) ? 1'b0 : 1'b1;
            step();
            checks++;
            if (err_o !== 1'b1 || diff_o !== '0 || underflow_o !== 1'b0) begin
                errors++;
                $display("FAIL error_case%0d got err=%b diff=%b uf=%b want err=1 diff=0 uf=0", n, err_o, diff_o, underflow_o);
            end
        end
        v_i = 0;
        step();
        yumi_i = 0;
    endtask

    task automatic test_reset_full();
        v_i = 1; a_i = 7'b0100000; b_i = 4'b0100; yumi_i = 0;
        step(); step();
        v_i = 0;
        reset = 1;
        step();
        reset = 0;
        checks++;
        if (v_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_full got v=%b rdy=%b want v=0 rdy=1", v_o, ready_o);
        end
        v_i = 1; a_i = 7'b0010000; b_i = 4'b0010;
        step();
        v_i = 0;
        checks++;
        if (v_o !== 1'b1 || diff_o !== 7'b0001000) begin
            errors++;
            $display("FAIL post_reset_first got v=%b diff=%b want v=1 diff=0001000", v_o, diff_o);
        end
        yumi_i = 1;
        step();
        yumi_i = 0;
    endtask

    task automatic test_final_drain();
        int budget;
        budget = 20;
        v_i = 0;
        while (v_o && budget > 0) begin
            yumi_i = 1;
            step();
            budget--;
        end
        yumi_i = 0;
        checks++;
        if (sb.size() != 0 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL final_drain got pending=%0d v=%b want pending=0 v=0", sb.size(), v_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_underflow_modulo();
        test_backpressure();
        test_error();
        test_reset_full();
        test_final_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
